// File: rtl/simple_ff_async_pkg.sv
// Shared constants and parameter checks for the simple_ff_async register.
// Holds the release synchroniser depth and the ASYNC mode validator.
package simple_ff_async_pkg;

    localparam int RST_SYNC_STAGES = 2;

    // ASYNC is carried as a packed string literal; only the two modes are legal.
    function automatic bit async_mode_valid(input logic [63:0] mode);
        return (mode == 64'("TRUE")) || (mode == 64'("FALSE"));
    endfunction

endpackage

// File: rtl/simple_ff_async_rst_release_sync.sv
// Reset release synchroniser: asserts asynchronously, releases after STAGES rising CK edges.
// Latency: assertion immediate, release STAGES edges after SR rises.
// Backpressure: none; free-running on CK.
module rst_release_sync #(
    parameter int STAGES = 2
) (
    input  logic CK,
    input  logic SR,
    output logic rst_n_sync
);

    if (STAGES < 2) begin : g_bad_stages
        $error("rst_release_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge CK or negedge SR) begin
        if (!SR) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_sync = sync_q[STAGES-1];

endmodule

// File: rtl/simple_ff_async.sv
// Clock-enabled D register, async active-low reset; ASYNC="FALSE" syncs reset release.
// Latency: D->Q one CK edge; reset assertion immediate. Stall: CE=0 holds Q.
// Optional even-parity output Q_PAR when SIMPLE_FF_ASYNC_PARITY_EN is defined.
module simple_ff_async
    import simple_ff_async_pkg::*;
#(
    parameter                   ASYNC = "TRUE",
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] SRVAL = '0
) (
    input  logic             CK,
    input  logic             SR,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
`ifdef SIMPLE_FF_ASYNC_PARITY_EN
    ,
    output logic             Q_PAR
`endif
);

    if (!async_mode_valid(64'(ASYNC))) begin : g_bad_async
        $error("simple_ff_async: ASYNC must be \"TRUE\" or \"FALSE\"");
    end

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("simple_ff_async: WIDTH must be in 1..64");
    end

    logic             rst_n_int;
    logic [WIDTH-1:0] q_r;

    // The synchroniser clears asynchronously, so assertion still reaches q_r with no clock.
    if (64'(ASYNC) == 64'("FALSE")) begin : g_sync_release
        rst_release_sync #(
            .STAGES (RST_SYNC_STAGES)
        ) u_rst_release_sync (
            .CK         (CK),
            .SR         (SR),
            .rst_n_sync (rst_n_int)
        );
    end else begin : g_async_release
        assign rst_n_int = SR;
    end

    always_ff @(posedge CK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            q_r <= SRVAL;
        end else if (CE) begin
            q_r <= D;
        end
    end

    assign Q = q_r;

`ifdef SIMPLE_FF_ASYNC_PARITY_EN
    logic q_par_r;

    // Parity of D is registered alongside Q so Q_PAR needs no XOR tree after the flop.
    always_ff @(posedge CK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            q_par_r <= ^SRVAL;
        end else if (CE) begin
            q_par_r <= ^D;
        end
    end

    assign Q_PAR = q_par_r;
`endif

endmodule

// File: tb/tb_simple_ff_async.sv
// Bench for simple_ff_async: async-release, sync-release and 8-bit/parity instances on one clock.
`timescale 1ns/1ps
module tb_simple_ff_async;

    localparam logic [7:0] W_SRVAL = 8'hA5;

    logic       CK   = 1'b0;
    logic       sr_a = 1'b1, ce_a = 1'b0, d_a = 1'b0;
    logic       sr_s = 1'b1, ce_s = 1'b0, d_s = 1'b0;
    logic       sr_w = 1'b1, ce_w = 1'b0;
    logic [7:0] d_w  = 8'h00;
    logic       q_a, q_s;
    logic [7:0] q_w;
`ifdef SIMPLE_FF_ASYNC_PARITY_EN
    logic       q_par_w;
`endif

    int tests = 0;
    int fails = 0;

    simple_ff_async #(.ASYNC("TRUE"), .WIDTH(1), .SRVAL(1'b0)) u_async (
        .CK(CK), .SR(sr_a), .CE(ce_a), .D(d_a), .Q(q_a)
    );

    simple_ff_async #(.ASYNC("FALSE"), .WIDTH(1), .SRVAL(1'b0)) u_sync (
        .CK(CK), .SR(sr_s), .CE(ce_s), .D(d_s), .Q(q_s)
    );

    simple_ff_async #(.ASYNC("TRUE"), .WIDTH(8), .SRVAL(W_SRVAL)) u_wide (
        .CK(CK), .SR(sr_w), .CE(ce_w), .D(d_w), .Q(q_w)
`ifdef SIMPLE_FF_ASYNC_PARITY_EN
        , .Q_PAR(q_par_w)
`endif
    );

    // Clock stays stopped until 1000ns, then 200ns period with the first rising edge at 1000ns.
    initial begin
        #1000;
        CK = 1'b1;
        forever #100 CK = ~CK;
    end

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset;
        #100;
        sr_a = 1'b0; sr_s = 1'b0; sr_w = 1'b0;
        ce_s = 1'b1; d_s = 1'b1; ce_w = 1'b1; d_w = 8'h3C;
        #1;
        tests++; if (q_a !== 1'b0) begin fails++; $display("FAIL reset_async_noclk: got %b want 0", q_a); end
        tests++; if (q_s !== 1'b0) begin fails++; $display("FAIL reset_sync_noclk: got %b want 0", q_s); end
        tests++; if (q_w !== W_SRVAL) begin fails++; $display("FAIL reset_wide_noclk: got %h want %h", q_w, W_SRVAL); end
`ifdef SIMPLE_FF_ASYNC_PARITY_EN
        tests++; if (q_par_w !== 1'b0) begin fails++; $display("FAIL reset_par_noclk: got %b want 0", q_par_w); end
`endif
        #400;
        tests++; if (q_w !== W_SRVAL) begin fails++; $display("FAIL reset_wide_hold: got %h want %h", q_w, W_SRVAL); end
        @(posedge CK);
        sr_a = 1'b1;
        #1;
        tests++; if (q_a !== 1'b0) begin fails++; $display("FAIL reset_release_edge: got %b want 0", q_a); end
        ce_w = 1'b0;
        sr_w = 1'b1;
    endtask

    task automatic test_ce_gating;
        ce_a = 1'b0;
        d_a  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            d_a = 1'b0;
            tests++; if (q_a !== 1'b0) begin fails++; $display("FAIL ce_gating[%0d]: got %b want 0", i, q_a); end
        end
    endtask

    task automatic test_load;
        ce_a = 1'b1; d_a = 1'b1;
        tick();
        tests++; if (q_a !== 1'b1) begin fails++; $display("FAIL load_one: got %b want 1", q_a); end
        d_a = 1'b0;
        tick();
        tests++; if (q_a !== 1'b0) begin fails++; $display("FAIL load_zero: got %b want 0", q_a); end
    endtask

    task automatic test_mid_reset;
        d_a = 1'b1;
        tick();
        tests++; if (q_a !== 1'b1) begin fails++; $display("FAIL mid_preload: got %b want 1", q_a); end
        #50;
        sr_a = 1'b0;
        #1;
        tests++; if (q_a !== 1'b0) begin fails++; $display("FAIL mid_assert: got %b want 0", q_a); end
        tick();
        tests++; if (q_a !== 1'b0) begin fails++; $display("FAIL mid_hold: got %b want 0", q_a); end
        sr_a = 1'b1; d_a = 1'b1;
        tick();
        tests++; if (q_a !== 1'b1) begin fails++; $display("FAIL mid_reload: got %b want 1", q_a); end
    endtask

    task automatic test_sync_release;
        tick();
        tests++; if (q_s !== 1'b0) begin fails++; $display("FAIL sync_in_reset: got %b want 0", q_s); end
        sr_s = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            tests++;
            if (q_s !== (e == 3 ? 1'b1 : 1'b0)) begin
                fails++; $display("FAIL sync_release_edge%0d: got %b want %b", e, q_s, (e == 3));
            end
        end
        d_s = 1'b0;
        tick();
        tests++; if (q_s !== 1'b0) begin fails++; $display("FAIL sync_load_zero: got %b want 0", q_s); end
        d_s = 1'b1;
        tick();
        #50;
        sr_s = 1'b0;
        #1;
        tests++; if (q_s !== 1'b0) begin fails++; $display("FAIL sync_mid_assert: got %b want 0", q_s); end
        sr_s = 1'b1;
    endtask

    task automatic test_wide_parity;
        tests++; if (q_w !== W_SRVAL) begin fails++; $display("FAIL wide_ce0_hold: got %h want %h", q_w, W_SRVAL); end
        ce_w = 1'b1; d_w = 8'h01;
        tick();
        tests++; if (q_w !== 8'h01) begin fails++; $display("FAIL wide_load01: got %h want 01", q_w); end
`ifdef SIMPLE_FF_ASYNC_PARITY_EN
        tests++; if (q_par_w !== 1'b1) begin fails++; $display("FAIL par_load01: got %b want 1", q_par_w); end
`endif
        d_w = 8'hFF;
        tick();
        tests++; if (q_w !== 8'hFF) begin fails++; $display("FAIL wide_loadFF: got %h want ff", q_w); end
`ifdef SIMPLE_FF_ASYNC_PARITY_EN
        tests++; if (q_par_w !== 1'b0) begin fails++; $display("FAIL par_loadFF: got %b want 0", q_par_w); end
`endif
    endtask

    // Reference: reset forces SRVAL at once; sync mode needs two released edges before loading.
    task automatic test_random;
        logic       exp_a, exp_s;
        logic [7:0] exp_w;
        int         rel_s;
        sr_a = 1'b0; sr_s = 1'b0; sr_w = 1'b0;
        exp_a = 1'b0; exp_s = 1'b0; exp_w = W_SRVAL; rel_s = 0;
        #1;
        for (int i = 0; i < 300; i++) begin
            sr_a = ($urandom_range(9) != 0);
            sr_s = ($urandom_range(9) != 0);
            sr_w = ($urandom_range(9) != 0);
            ce_a = 1'($urandom); d_a = 1'($urandom);
            ce_s = 1'($urandom); d_s = 1'($urandom);
            ce_w = 1'($urandom); d_w = 8'($urandom);
            if (!sr_a) exp_a = 1'b0;
            if (!sr_s) begin exp_s = 1'b0; rel_s = 0; end
            if (!sr_w) exp_w = W_SRVAL;
            #1;
            tests++; if (q_a !== exp_a) begin fails++; $display("FAIL rnd_async_pre[%0d]: got %b want %b", i, q_a, exp_a); end
            tests++; if (q_s !== exp_s) begin fails++; $display("FAIL rnd_sync_pre[%0d]: got %b want %b", i, q_s, exp_s); end
            tests++; if (q_w !== exp_w) begin fails++; $display("FAIL rnd_wide_pre[%0d]: got %h want %h", i, q_w, exp_w); end
            tick();
            if (sr_a && ce_a) exp_a = d_a;
            if (sr_s) begin
                if (rel_s < 2) rel_s++;
                else if (ce_s) exp_s = d_s;
            end
            if (sr_w && ce_w) exp_w = d_w;
            tests++; if (q_a !== exp_a) begin fails++; $display("FAIL rnd_async[%0d]: got %b want %b", i, q_a, exp_a); end
            tests++; if (q_s !== exp_s) begin fails++; $display("FAIL rnd_sync[%0d]: got %b want %b", i, q_s, exp_s); end
            tests++; if (q_w !== exp_w) begin fails++; $display("FAIL rnd_wide[%0d]: got %h want %h", i, q_w, exp_w); end
`ifdef SIMPLE_FF_ASYNC_PARITY_EN
            tests++; if (q_par_w !== ^exp_w) begin fails++; $display("FAIL rnd_par[%0d]: got %b want %b", i, q_par_w, ^exp_w); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_ce_gating();
        test_load();
        test_mid_reset();
        test_sync_release();
        test_wide_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simple_ff_async.md
Name: simple_ff_async

Overview:
- Parameterised, clock-enabled D register with an asynchronous active-low reset.
- Used as the basic storage primitive in control paths, where the reset must clear state before the clock is running.
- A parameter chooses whether reset release takes effect immediately or through an internal two-stage release synchroniser.
- In both modes, reset assertion is always asynchronous.

Parameters:
- ASYNC, "TRUE", string.
  - "TRUE": reset asserts and releases asynchronously.
  - "FALSE": reset asserts asynchronously and releases synchronised to CK after 2 edges.
  - Any other value is an elaboration error.
- WIDTH, 1, width of D and Q; legal range 1..64.
- SRVAL, '0, WIDTH-bit value loaded into Q while reset is active.

Ports:
- CK  input  1  clock; all sampling on the rising edge.
- SR  input  1  reset; asynchronous, active-low (0 = reset).
- CE  input  1  clock enable, active-high.
- D   input  WIDTH  data in.
- Q   output  WIDTH  registered data out.

Behaviour:
- Interface: one clock (CK). Reset SR is asynchronous and active-low.
- Reset assertion (SR=0), both modes:
  - Q = SRVAL immediately, with no CK edge required. This must hold even while CK is stopped.
  - Q is held at SRVAL for as long as SR=0. CE and D are ignored.
- Internal reset, ASYNC="TRUE": the internal reset is SR itself.
  - The first CK rising edge with SR=1 samples normally.
- Internal reset, ASYNC="FALSE":
  - The internal reset is the output of a 2-flop release synchroniser. Both flops are cleared asynchronously by SR=0, and both shift in 1 on CK.
  - The internal reset deasserts on the 2nd CK rising edge after SR rises.
  - Q stays at SRVAL through those edges. Normal sampling starts at the 3rd edge.
- Normal operation, on a CK rising edge with the internal reset inactive:
  - CE=1: Q <= D.
  - CE=0: Q holds.
  - Latency D->Q is 1 cycle.
- Simultaneous events:
  - SR falling in the same instant as a CK edge: reset wins, Q = SRVAL.
  - SR rising coincident with a CK edge (ASYNC="TRUE"): that edge does not load D.
- Reset mid-operation: Q returns to SRVAL asynchronously. Loaded data is lost.
- No X propagation from D while CE=0.

Optional Feature:
- Macro: SIMPLE_FF_ASYNC_PARITY_EN.
- When defined:
  - Adds output Q_PAR (1 bit), a registered even-parity bit equal to XOR-reduce(Q) at all times.
  - Q_PAR updates on the same edge as Q, under the same CE and reset.
  - Reset value of Q_PAR is XOR-reduce(SRVAL).
- When undefined: the Q_PAR port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package simple_ff_async_pkg holds:
  - constant RST_SYNC_STAGES = 2;
  - a function that validates the ASYNC string.
- One sub-module, rst_release_sync:
  - Parameter STAGES.
  - Ports CK, SR in, rst_n_sync out.
  - Instantiated only when ASYNC="FALSE"; otherwise generated as a pass-through.

Test Plan:
- Reset with clock stopped: CK held 0. At t=100ns drive SR=0 -> Q=SRVAL (0) with no CK edge. Release SR on the first CK edge (CK starts at 1000ns, 200ns period) -> Q remains 0.
- CE gating: CE=0, pulse D=1 for one cycle -> Q stays 0 across all edges.
- Load: CE=1, D=1 -> Q=1 one edge later. Then D=0 -> Q=0 on the next edge.
- Mid-operation reset: Q=1 with CE=1, drive SR=0 between edges -> Q=0 immediately. Then SR=1 with D=1 -> Q=1 after the next edge (ASYNC="TRUE").
- Synchronised release: ASYNC="FALSE", CE=1, D=1, release SR -> Q=0 after edges 1 and 2, Q=1 after edge 3.
- Width and parity: WIDTH=8, SRVAL=8'hA5 with SIMPLE_FF_ASYNC_PARITY_EN defined.
  - Reset -> Q=8'hA5, Q_PAR=0.
  - Load 8'h01 -> Q_PAR=1.
